// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage with a two-entry skid buffer (M drives outputs, K catches overflow).
// Define DECODE_ILLEGAL_EN to flag illegal words and suppress their register-usage flags.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;
  } entry_t;
  entry_t dec, m_q, m_d, k_q, k_d;
  logic m_v_q, m_v_d, k_v_q, k_v_d, rdy_q, rdy_d;
  logic [6:0] op;
  logic is_r, is_i, is_s, is_b, is_u, is_j, ill, acc, ret;
  logic signed [31:0] imm32;
  always_comb begin
    op = in_inst[6:0];
    is_r = op == 7'b0110011 || (XLEN == 64 && op == 7'b0111011);
    is_i = op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111} ||
           (XLEN == 64 && op == 7'b0011011);
    is_s = op == 7'b0100011;
    is_b = op == 7'b1100011;
    is_u = op inside {7'b0110111, 7'b0010111};
    is_j = op == 7'b1101111;
    imm32 = is_i ? {{20{in_inst[31]}}, in_inst[31:20]} :
            is_s ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
            is_b ? {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
            is_u ? {in_inst[31:12], 12'b0} :
            is_j ? {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} : 32'sd0;
`ifdef DECODE_ILLEGAL_EN
    ill = !(is_r || is_i || is_s || is_b || is_u || is_j) || in_inst[1:0] != 2'b11;
`else
    ill = 1'b0;
`endif
    dec.inst = in_inst;
    dec.pc = in_pc;
    dec.imm = XLEN'(imm32);
    dec.fmt = is_r ? 3'd1 : is_i ? 3'd2 : is_s ? 3'd3 : is_b ? 3'd4 : is_u ? 3'd5 : is_j ? 3'd6 : 3'd0;
    dec.rs1_used = !ill && (is_r || is_i || is_s || is_b);
    dec.rs2_used = !ill && (is_r || is_s || is_b);
    dec.rd_we = !ill && (is_r || is_i || is_u || is_j) && in_inst[11:7] != 5'd0;
    dec.illegal = ill;
  end
  // M refills from K first so ordering stays FIFO; K only fills while M is stalled.
  always_comb begin
    acc = in_valid && rdy_q && !flush;
    ret = m_v_q && out_ready;
    m_d = m_q;
    k_d = k_q;
    m_v_d = m_v_q;
    k_v_d = k_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      k_v_d = 1'b0;
    end else if (!m_v_q || ret) begin
      m_v_d = k_v_q || acc;
      m_d = k_v_q ? k_q : acc ? dec : m_q;
      k_v_d = k_v_q && acc;
      k_d = (k_v_q && acc) ? dec : k_q;
    end else if (acc) begin
      k_v_d = 1'b1;
      k_d = dec;
    end
    rdy_d = !k_v_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      k_q <= '0;
      m_v_q <= 1'b0;
      k_v_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      m_q <= m_d;
      k_q <= k_d;
      m_v_q <= m_v_d;
      k_v_q <= k_v_d;
      rdy_q <= rdy_d;
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = m_v_q;
  assign out_inst = m_q.inst;
  assign out_pc = m_q.pc;
  assign out_opcode = m_q.inst[6:0];
  assign out_funct3 = m_q.inst[14:12];
  assign out_funct7 = m_q.inst[31:25];
  assign out_rs1 = m_q.inst[19:15];
  assign out_rs2 = m_q.inst[24:20];
  assign out_rd = m_q.inst[11:7];
  assign out_imm = m_q.imm;
  assign out_fmt = m_q.fmt;
  assign out_rs1_used = m_q.rs1_used;
  assign out_rs2_used = m_q.rs2_used;
  assign out_rd_we = m_q.rd_we;
  assign out_illegal = m_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench driving an XLEN=32 and an XLEN=64 decode_stage in lockstep.
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic r32, v32, r64, v64;
  logic [31:0] i32, i64, p32, m32;
  logic [63:0] p64, m64;
  logic [6:0] op32, f7_32, op64, f7_64;
  logic [2:0] f3_32, fmt32, f3_64, fmt64;
  logic [4:0] s1_32, s2_32, d32, s1_64, s2_64, d64;
  logic u1_32, u2_32, we32, il32, u1_64, u2_64, we64, il64;
  int checks = 0, errs = 0;
  always #5 clk = ~clk;
`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  decode_stage #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready), .out_inst(i32), .out_pc(p32),
    .out_opcode(op32), .out_funct3(f3_32), .out_funct7(f7_32), .out_rs1(s1_32), .out_rs2(s2_32), .out_rd(d32),
    .out_imm(m32), .out_fmt(fmt32), .out_rs1_used(u1_32), .out_rs2_used(u2_32), .out_rd_we(we32), .out_illegal(il32));
  decode_stage #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready), .out_inst(i64), .out_pc(p64),
    .out_opcode(op64), .out_funct3(f3_64), .out_funct7(f7_64), .out_rs1(s1_64), .out_rs2(s2_64), .out_rd(d64),
    .out_imm(m64), .out_fmt(fmt64), .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_rd_we(we64), .out_illegal(il64));
  typedef struct {
    logic [2:0] fmt;
    logic [63:0] imm;
    logic r1, r2, we, ill;
  } exp_t;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    exp_t e32, e64;
  } item_t;
  item_t q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference decode: immediates built arithmetically from the signed word.
  function automatic exp_t model(input logic [31:0] i, input bit x64);
    exp_t e;
    longint s;
    s = longint'($signed(i));
    case (i[6:0])
      7'h33: e.fmt = 3'd1;
      7'h3B: e.fmt = x64 ? 3'd1 : 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd2;
      7'h1B: e.fmt = x64 ? 3'd2 : 3'd0;
      7'h23: e.fmt = 3'd3;
      7'h63: e.fmt = 3'd4;
      7'h37, 7'h17: e.fmt = 3'd5;
      7'h6F: e.fmt = 3'd6;
      default: e.fmt = 3'd0;
    endcase
    case (e.fmt)
      3'd2: e.imm = 64'(s >>> 20);
      3'd3: e.imm = 64'((s >>> 25) * 32) | 64'(i[11:7]);
      3'd4: e.imm = 64'((s >>> 31) * 4096) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
      3'd5: e.imm = 64'(s) & ~64'hFFF;
      3'd6: e.imm = 64'((s >>> 31) * 1048576) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
      default: e.imm = 64'd0;
    endcase
    if (!x64) e.imm = {32'd0, e.imm[31:0]};
    e.ill = ILL_EN && (e.fmt == 3'd0 || i[1:0] != 2'b11);
    e.r1 = !e.ill && e.fmt inside {3'd1, 3'd2, 3'd3, 3'd4};
    e.r2 = !e.ill && e.fmt inside {3'd1, 3'd3, 3'd4};
    e.we = !e.ill && e.fmt inside {3'd1, 3'd2, 3'd5, 3'd6} && i[11:7] != 5'd0;
    return e;
  endfunction
  // Monitor: occupancy implies out_valid/in_ready; the head entry must be on the outputs every valid cycle.
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      chk("out_valid32", v32, q.size() > 0);
      chk("in_ready32", r32, q.size() < 2);
      chk("out_valid64", v64, q.size() > 0);
      chk("in_ready64", r64, q.size() < 2);
      if (v32 && q.size() > 0) begin
        chk("inst32", i32, q[0].inst);
        chk("pc32", p32, q[0].pc[31:0]);
        chk("fields32", {op32, f3_32, f7_32, s1_32, s2_32, d32},
            {q[0].inst[6:0], q[0].inst[14:12], q[0].inst[31:25], q[0].inst[19:15], q[0].inst[24:20], q[0].inst[11:7]});
        chk("imm32", m32, q[0].e32.imm);
        chk("fmt32", fmt32, q[0].e32.fmt);
        chk("flags32", {u1_32, u2_32, we32, il32}, {q[0].e32.r1, q[0].e32.r2, q[0].e32.we, q[0].e32.ill});
      end
      if (v64 && q.size() > 0) begin
        chk("inst64", i64, q[0].inst);
        chk("pc64", p64, q[0].pc);
        chk("fields64", {op64, f3_64, f7_64, s1_64, s2_64, d64},
            {q[0].inst[6:0], q[0].inst[14:12], q[0].inst[31:25], q[0].inst[19:15], q[0].inst[24:20], q[0].inst[11:7]});
        chk("imm64", m64, q[0].e64.imm);
        chk("fmt64", fmt64, q[0].e64.fmt);
        chk("flags64", {u1_64, u2_64, we64, il64}, {q[0].e64.r1, q[0].e64.r2, q[0].e64.we, q[0].e64.ill});
      end
      if (flush) q.delete();
      else begin
        if (v32 && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && r32) q.push_back('{in_inst, in_pc, model(in_inst, 1'b0), model(in_inst, 1'b1)});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_inst = inst;
    in_pc = pc;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = r32;
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: in_ready stayed 0 for inst %h", inst);
    end
    step();
    in_valid = 1'b0;
  endtask
  logic [6:0] ops[16] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h1B,
                          7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h2B};
  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 15)];
    if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
    return w;
  endfunction
  initial begin
    logic [31:0] held;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_outs32", {v32, i32, p32, m32, fmt32, u1_32, u2_32, we32, il32}, '0);
    chk("rst_outs64", {v64, i64, p64, m64, fmt64, u1_64, u2_64, we64, il64}, '0);
    chk("rst_ready", {r32, r64}, 2'b11);
    send(32'hFFF00093, 64'h1000);
    chk("addi_fmt", fmt32, 3'd2);
    chk("addi_imm", m32, 32'hFFFFFFFF);
    chk("addi_rd", d32, 5'd1);
    chk("addi_flags", {we32, u1_32, u2_32}, 3'b110);
    send(32'h00112623, 64'h1004);
    chk("sw_fmt_imm", {fmt32, m32}, {3'd3, 32'd12});
    chk("sw_regs", {s1_32, s2_32, we32}, {5'd2, 5'd1, 1'b0});
    send(32'hFE000EE3, 64'h1008);
    chk("beq_fmt_imm", {fmt32, m32}, {3'd4, 32'hFFFFFFFC});
    send(32'h800002B7, 64'h100C);
    chk("lui64", {fmt64, m64, d64}, {3'd5, 64'hFFFFFFFF80000000, 5'd5});
    send(32'h0000007F, 64'h1010);
    chk("bad_op", {il32, fmt32, we32}, {ILL_EN, 3'd0, 1'b0});
    step();
    out_ready = 1'b0;
    send(32'h00A00113, 64'h2000);
    send(32'h00B00193, 64'h2004);
    chk("stall_ready", r32, 1'b0);
    held = i32;
    fork
      send(32'h00C00213, 64'h2008);
      begin
        repeat (3) step();
        chk("stall_hold", i32, held);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    out_ready = 1'b0;
    send(32'h00100093, 64'h3000);
    send(32'h00200093, 64'h3004);
    in_valid = 1'b1;
    in_inst = 32'h12345037;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", v32, 1'b0);
    chk("flush_ready", r32, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_dropped", v32, 1'b0);
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1 chk("async_rst", {v32, r32, v64, r64}, 4'b0101);
        repeat (2) step();
        rst_n = 1'b1;
      end
      in_valid = $urandom_range(0, 3) != 0;
      in_inst = rand_inst();
      in_pc = {$urandom, $urandom};
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("drain_empty", {v32, v64, 32'(q.size())}, '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RISC-V instruction-decode pipeline stage for XLEN 32 or 64. Sits between fetch and register-read/execute, taking one instruction word plus PC per valid/ready transfer and presenting extracted fields, a single format-selected XLEN-wide immediate, format class and register-usage flags one cycle later. A two-entry skid buffer gives full throughput while `in_ready` stays purely registered. A synchronous flush discards everything in flight.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; sets immediate and PC width and enables RV64 `*W` opcodes.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: discard all buffered instructions.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept; registered.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction address.
- `out_valid` output 1: decoded instruction valid.
- `out_ready` input 1: downstream accepts.
- `out_inst` output 32: instruction word, passed through.
- `out_pc` output XLEN: PC, passed through.
- `out_opcode` output 7, `out_funct3` output 3, `out_funct7` output 7: fields from bits [6:0], [14:12], [31:25].
- `out_rs1` output 5, `out_rs2` output 5, `out_rd` output 5: fields from bits [19:15], [24:20], [11:7].
- `out_imm` output XLEN: sign-extended immediate for the decoded format; 0 for R/none.
- `out_fmt` output 3: 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
- `out_rs1_used` output 1, `out_rs2_used` output 1, `out_rd_we` output 1: register-usage flags.
- `out_illegal` output 1: illegal instruction (see Configuration).

## Operation
- Format by opcode:
  - R: 0110011, plus 0111011 when XLEN=64.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111, plus 0011011 when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - Anything else: none.
- Immediates: standard RV encodings, sign-extended from inst[31] to XLEN.
  - B and J have bit 0 = 0.
  - U is {inst[31:12], 12'b0}, sign-extended to XLEN.
- Register-usage flags:
  - `rs1_used` for R, I, S, B; `rs2_used` for R, S, B.
  - `rd_we` for R, I, U, J and only when rd != 0.
- Decode is combinational on the input word. All outputs come from the registered buffer entry presented at the head.
- Buffer: main entry M, which drives the outputs, and skid entry K.
  - Accept on `in_valid && in_ready`. Retire on `out_valid && out_ready`.
  - Accept while M is empty, or while M retires this cycle: new word goes to M, or K moves into M and the new word goes to K.
  - Accept while M is full and stalled: word goes to K.
  - `in_ready` next = !(K full after this cycle).
- Ordering is strict FIFO; no instruction is duplicated or lost except by flush.

## Timing
- Reset, asynchronous: M and K empty; `out_valid`=0; `in_ready`=1; every other output 0.
- Latency: accepted at edge N, visible on outputs after edge N (cycle N+1) if M was empty or retiring.
- Throughput: one per cycle with `out_ready` held high.
- `out_ready` low: outputs hold stable.
  - A second accepted word fills K; `in_ready` drops the following cycle.
  - `in_ready` rises the cycle after M retires.
- Flush:
  - Empties M and K at the next edge; `out_valid`=0 the following cycle; `in_ready`=1.
  - An input offered in the flush cycle is dropped, even if `in_ready`=1.
  - A retire in the flush cycle still completes downstream.
- Simultaneous accept and retire with K full cannot occur, because `in_ready`=0.
- Reset asserted mid-stream clears state immediately. First accept is possible in the first cycle after deassertion.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - `out_illegal`=1 when fmt is none or inst[1:0] != 2'b11.
  - An illegal instruction forces `out_rd_we`, `out_rs1_used` and `out_rs2_used` to 0; all other fields pass through.
- Not defined: `out_illegal` is constant 0 and the flags follow format only. Unknown opcodes yield fmt 0, imm 0, all flags 0.

## Test plan
- XLEN=32, input 0xFFF00093 (addi x1,x0,-1) -> next cycle fmt=2, imm=0xFFFFFFFF, rd=1, rd_we=1, rs1_used=1, rs2_used=0.
- Back-to-back inputs with `out_ready`=1:
  - 0x00112623 (sw x1,12(x2)) -> fmt=3, imm=12, rs1=2, rs2=1, rd_we=0.
  - 0xFE000EE3 (beq -4) -> fmt=4, imm=0xFFFFFFFC.
  - One output per cycle, in order.
- XLEN=64, input 0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000, fmt=5, rd=5.
- Hold `out_ready`=0 and stream 3 words:
  - First two are accepted; `in_ready`=0 from the cycle after the second accept.
  - Outputs are stable.
  - Releasing `out_ready` drains all three in order, with no loss or duplication.
- Two words buffered, then pulse `flush` while `in_valid`=1 -> `out_valid`=0 next cycle, `in_ready`=1, and the offered word never appears.
- With `DECODE_ILLEGAL_EN`, input 0x0000007F -> illegal=1, fmt=0, rd_we=0. Without it -> illegal=0, fmt=0.
